// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone shared-bus arbiter/crossbar.
// Latency: n/a (types, constants and a combinational round-robin pick).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_t;

    // Width of the stalled-strobe timeout counter.
    localparam int WB_TO_W  = 8;
    // Largest master count the round-robin helper handles.
    localparam int WB_MAX_M = 8;

    // One-hot grant of the first set bit of req, scanning upward from
    // (last + 1) with wrap at n. Returns zero when nothing is requested.
    function automatic logic [WB_MAX_M-1:0] rr_pick(
        input logic [WB_MAX_M-1:0] req,
        input logic [2:0]          last,
        input int                  n
    );
        logic [WB_MAX_M-1:0] g;
        logic                found;
        int                  idx;
        g     = '0;
        found = 1'b0;
        for (int i = 1; i <= WB_MAX_M; i++) begin
            if (i <= n) begin
                idx = int'(last) + i;
                if (idx >= n) idx = idx - n;
                if (!found && req[3'(idx)]) begin
                    g[3'(idx)] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// Round-robin bus arbiter: owner holds the bus until it drops its request.
// Latency: grant registered, appears one cycle after the request is sampled.
// Backpressure: none; requesters simply wait until granted.
// Ports: req = per-master cyc, rel = owner has dropped cyc this cycle,
//        gnt = one-hot owner (zero when idle), gnt_idx = binary owner index.
module wb_rr_arb
    import wb_pkg::*;
#(
    parameter int NM = 2,
    parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [NM-1:0] req,
    input  logic          rel,
    output logic [NM-1:0] gnt,
    output logic [IW-1:0] gnt_idx
);

    arb_state_t          state;
    logic [IW-1:0]       last_owner;
    logic [IW-1:0]       base;
    logic [WB_MAX_M-1:0] req_w;
    logic [WB_MAX_M-1:0] pick_w;
    logic [NM-1:0]       pick;
    logic [IW-1:0]       pick_idx;

    // When idle, rotate from the last owner; when the owner releases,
    // rotate from the owner itself (its own request is already low).
    always_comb begin
        base          = (state == ARB_IDLE) ? last_owner : gnt_idx;
        req_w         = '0;
        req_w[NM-1:0] = req;
        pick_w        = rr_pick(req_w, 3'(base), NM);
        pick          = pick_w[NM-1:0];
        pick_idx      = '0;
        for (int i = 0; i < WB_MAX_M; i++) begin
            if (pick_w[i]) pick_idx = IW'(i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            last_owner <= IW'(NM - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state   <= ARB_OWNED;
                        gnt     <= pick;
                        gnt_idx <= pick_idx;
                    end
                end
                ARB_OWNED: begin
                    if (rel) begin
                        last_owner <= gnt_idx;
                        if (|req) begin
                            gnt     <= pick;
                            gnt_idx <= pick_idx;
                        end else begin
                            state <= ARB_IDLE;
                            gnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_arb_xbar.sv
// Wishbone shared-bus interconnect: NM masters, NS slaves, round-robin owner.
// Latency: grant +1 cycle after cyc; request/response paths combinational.
// Backpressure: slaves stall via withheld ack; stalls end in err after TIMEOUT.
// Ports: m_* master side (packed per master), s_* slave side (cyc/stb one-hot
//        per slave, other request fields shared), gnt_o = one-hot owner.
module wb_arb_xbar
    import wb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int NS       = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int SEL_BITS = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*(DW/8)-1:0] m_sel_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    output logic [NM*DW-1:0]     m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    output logic                 s_we_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    output logic [NM-1:0]        gnt_o
);

    localparam int                 SW      = DW / 8;
    localparam int                 IW      = (NM > 1) ? $clog2(NM) : 1;
    localparam bit                 TO_EN   = (TIMEOUT > 0);
    localparam logic [WB_TO_W-1:0] TO_LAST = WB_TO_W'(TIMEOUT - 1);

    generate
        if (NM < 1 || NM > WB_MAX_M || NS < 1 || NS > (1 << SEL_BITS) ||
            SEL_BITS > AW || (DW % 8) != 0 || TIMEOUT < 0 || TIMEOUT > 255) begin : g_bad_params
            $error("wb_arb_xbar: illegal parameter combination");
        end
    endgenerate

    logic [NM-1:0]         gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  busy;
    logic                  rel;
    logic                  own_cyc, own_stb, own_we;
    logic [SW-1:0]         own_sel;
    logic [AW-1:0]         own_adr;
    logic [DW-1:0]         own_dat;
    logic [SEL_BITS-1:0]   idx;
    logic                  dec_hit, hit;
    logic                  sack, serr;
    logic [DW-1:0]         sdat;
    logic                  to_drop, to_exp;
    logic                  err_pulse;
    logic [WB_TO_W-1:0]    to_cnt;

    wb_rr_arb #(.NM(NM), .IW(IW)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (m_cyc_i),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign busy  = |gnt;
    assign rel   = busy & ~own_cyc;
    assign gnt_o = gnt;

    // Owner request mux; everything reads zero while the bus is idle.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_sel = '0;
        own_adr = '0;
        own_dat = '0;
        for (int i = 0; i < NM; i++) begin
            if (busy && (gnt_idx == IW'(i))) begin
                own_cyc = m_cyc_i[i];
                own_stb = m_stb_i[i];
                own_we  = m_we_i[i];
                own_sel = m_sel_i[i*SW +: SW];
                own_adr = m_adr_i[i*AW +: AW];
                own_dat = m_dat_i[i*DW +: DW];
            end
        end
    end

    assign idx     = own_adr[AW-1 -: SEL_BITS];
    assign dec_hit = (int'(idx) < NS);
    assign hit     = busy & dec_hit;

    assign s_we_o  = own_we;
    assign s_sel_o = own_sel;
    assign s_adr_o = own_adr;
    assign s_dat_o = own_dat;

    // Final stalled cycle: strobe is withdrawn regardless of a same-cycle
    // ack so the slave strobe never depends combinationally on s_ack_i.
    assign to_drop = TO_EN && hit && own_stb && (to_cnt == TO_LAST);
    // A same-cycle ack or slave error wins over the timeout error.
    assign to_exp  = to_drop & ~sack & ~serr;

    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        sack    = 1'b0;
        serr    = 1'b0;
        sdat    = '0;
        for (int s = 0; s < NS; s++) begin
            if (hit && (int'(idx) == s)) begin
                s_cyc_o[s] = own_cyc;
                s_stb_o[s] = own_stb & ~to_drop;
                sack       = s_ack_i[s];
                serr       = s_err_i[s];
                sdat       = s_dat_i[s*DW +: DW];
            end
        end
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        for (int i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                m_ack_o[i]          = sack;
                m_err_o[i]          = serr | err_pulse | to_exp;
                m_dat_o[i*DW +: DW] = sdat;
            end
        end
    end

    // err_pulse self-clears after one cycle, so a held miss errors on
    // alternate cycles. The counter clears on any cycle that is not a
    // stalled hit, which covers ack/err, stb low, and owner release.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pulse <= 1'b0;
            to_cnt    <= '0;
        end else begin
            err_pulse <= busy & own_cyc & own_stb & ~dec_hit & ~err_pulse;
            if (TO_EN && hit && own_cyc && own_stb && !sack && !serr && !to_drop)
                to_cnt <= to_cnt + WB_TO_W'(1);
            else
                to_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arb_xbar.sv
module tb_wb_arb_xbar;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NM-1:0]      m_cyc, m_stb, m_we, m_ack, m_err, gnt;
    logic [NM*SW-1:0]   m_sel;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat_w, m_dat_r;
    logic [NS-1:0]      s_cyc, s_stb, s_ack, s_err;
    logic               s_we;
    logic [SW-1:0]      s_sel;
    logic [AW-1:0]      s_adr;
    logic [DW-1:0]      s_dat_w;
    logic [NS*DW-1:0]   s_dat_r;

    always #5 clk = ~clk;

    wb_arb_xbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_BITS(4), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_dat_o(m_dat_r),
        .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
        .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(gnt)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: owner index (-1 = idle), last owner, stalled-cycle
    // count of the current transfer, pending decode-miss error.
    int own   = -1;
    int last  = NM - 1;
    int stall = 0;
    bit pulse = 1'b0;

    // Outputs observed in the most recent step.
    logic [NM-1:0]    o_gnt, o_ack, o_err;
    logic [NS-1:0]    o_stb;
    logic [NM*DW-1:0] o_mdat;

    int rem [2];
    bit gap [2];
    int order [$];
    logic [NM-1:0] prev_g;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [NM-1:0] req, input int from);
        for (int k = 1; k <= NM; k++)
            if (req[(from + k) % NM]) return (from + k) % NM;
        return -1;
    endfunction

    // One bus cycle: check outputs against the model mid-cycle, advance the
    // model with the inputs of this cycle, return just after the next edge.
    task automatic step();
        logic [NM-1:0]    e_gnt, e_ack, e_err;
        logic [NS-1:0]    e_cyc, e_stb;
        logic [NM*DW-1:0] e_mdat;
        logic             e_we;
        logic [SW-1:0]    e_sel;
        logic [AW-1:0]    e_adr;
        logic [DW-1:0]    e_dat;
        int               slot;
        bit               hit, ack, serr, expire, nxt_pulse;
        @(negedge clk);
        e_gnt = '0; e_ack = '0; e_err = '0; e_cyc = '0; e_stb = '0; e_mdat = '0;
        e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
        slot = 0; hit = 1'b0; ack = 1'b0; serr = 1'b0; expire = 1'b0;
        if (own >= 0) begin
            e_gnt[own] = 1'b1;
            e_we  = m_we[own];
            e_sel = m_sel[own*SW +: SW];
            e_adr = m_adr[own*AW +: AW];
            e_dat = m_dat_w[own*DW +: DW];
            slot  = int'(e_adr[31:28]);
            hit   = (slot < NS);
            if (hit) begin
                ack    = s_ack[slot];
                serr   = s_err[slot];
                expire = m_stb[own] && (stall == TO - 1);
                e_cyc[slot] = m_cyc[own];
                e_stb[slot] = m_stb[own] && !expire;
                e_mdat[own*DW +: DW] = s_dat_r[slot*DW +: DW];
            end
            e_ack[own] = ack;
            e_err[own] = serr || pulse || (expire && !ack && !serr);
        end
        chk("gnt", gnt, e_gnt);
        chk("s_cyc", s_cyc, e_cyc);
        chk("s_stb", s_stb, e_stb);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_dat", m_dat_r, e_mdat);
        chk("s_we", s_we, e_we);
        chk("s_sel", s_sel, e_sel);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat", s_dat_w, e_dat);
        o_gnt = gnt; o_ack = m_ack; o_err = m_err; o_stb = s_stb; o_mdat = m_dat_r;
        if (rst) begin
            own = -1; last = NM - 1; stall = 0; pulse = 1'b0;
        end else begin
            nxt_pulse = (own >= 0) && m_cyc[own] && m_stb[own] && !hit && !pulse;
            if ((own >= 0) && hit && m_cyc[own] && m_stb[own] && !ack && !serr && !expire)
                stall = stall + 1;
            else
                stall = 0;
            pulse = nxt_pulse;
            if (own < 0) begin
                if (|m_cyc) own = rr(m_cyc, last);
            end else if (!m_cyc[own]) begin
                last = own;
                own  = (|m_cyc) ? rr(m_cyc, own) : -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        m_cyc = '0; m_stb = '0; s_ack = '0; s_err = '0;
    endtask

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '1; m_adr = '0; m_dat_w = '0;
        s_ack = '0; s_err = '0; s_dat_r = '0;
        step();
        step();
        chk("reset_gnt", o_gnt, 0);
        chk("reset_err", o_err, 0);
        rst = 1'b0;

        // Round-robin: both masters, three single transfers each.
        m_adr = {32'h2000_0200, 32'h0000_0100};
        rem[0] = 3; rem[1] = 3; gap[0] = 1'b0; gap[1] = 1'b0;
        prev_g = '0;
        for (int c = 0; c < 80 && (rem[0] > 0 || rem[1] > 0); c++) begin
            for (int k = 0; k < NM; k++) begin
                m_cyc[k] = !gap[k] && (rem[k] > 0);
                m_stb[k] = m_cyc[k];
                gap[k]   = 1'b0;
            end
            step();
            chk("rr_onehot", 128'($countones(o_gnt) <= 1), 1);
            if (o_gnt != 0 && o_gnt != prev_g) order.push_back(o_gnt[1] ? 1 : 0);
            prev_g = o_gnt;
            for (int k = 0; k < NM; k++) begin
                if (o_ack[k]) begin
                    rem[k] = rem[k] - 1;
                    gap[k] = 1'b1;
                end
            end
            s_ack = o_stb & ~s_ack;
        end
        chk("rr_done", rem[0] + rem[1], 0);
        chk("rr_len", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++) chk("rr_order", order[i], i % 2);
        quiet(); step(); step();

        // Single master read via slave 1.
        m_we = '0;
        m_adr[31:0] = 32'h1000_0040;
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
        chk("rd_gnt_before", o_gnt, 0);
        step();
        chk("rd_gnt", o_gnt, 2'b01);
        chk("rd_stb", o_stb, 3'b010);
        s_ack = 3'b010; s_dat_r[63:32] = 32'hDEAD_BEEF;
        step();
        chk("rd_ack", o_ack[0], 1);
        chk("rd_dat", o_mdat[31:0], 32'hDEAD_BEEF);
        quiet(); step(); step();

        // Decode miss: m1 writes to an unmapped slot and holds stb.
        m_adr[63:32] = 32'h5000_0000; m_we = 2'b10; m_dat_w[63:32] = 32'h1234_5678;
        m_cyc = 2'b10; m_stb = 2'b10;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("miss_stb", o_stb, 0);
            chk("miss_err", o_err[1], i % 2);
        end
        quiet(); m_we = '0; step(); step();

        // Timeout: slave 0 never answers.
        m_adr[31:0] = 32'h0000_0000;
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("to_err", o_err[0], (i == 4 || i == 8) ? 1 : 0);
            chk("to_stb", o_stb, (i == 4 || i == 8) ? 3'b000 : 3'b001);
        end
        quiet(); step(); step();

        // Ack arriving on the cycle the timeout would fire.
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
        for (int i = 1; i <= 3; i++) step();
        s_ack = 3'b001;
        step();
        chk("tie_ack", o_ack[0], 1);
        chk("tie_err", o_err[0], 0);
        quiet(); step(); step();

        // Reset in the middle of an m0 transfer with m1 also requesting.
        m_adr = {32'h2000_0000, 32'h0000_0010};
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
        step();
        m_cyc = 2'b11; m_stb = 2'b11;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_gnt", o_gnt, 0);
        chk("rst_stb", o_stb, 0);
        chk("rst_ack", o_ack, 0);
        chk("rst_err", o_err, 0);
        step();
        chk("rst_regrant", o_gnt, 2'b01);
        quiet(); step(); step();

        // Randomized traffic against the model.
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 5) == 0) m_cyc[k] = ~m_cyc[k];
                m_stb[k] = m_cyc[k] && ($urandom_range(0, 3) != 0);
                m_we[k]  = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0)
                    m_adr[k*AW +: AW] = {4'($urandom_range(0, 5)), 28'($urandom)};
                m_sel[k*SW +: SW]   = 4'($urandom);
                m_dat_w[k*DW +: DW] = $urandom;
            end
            for (int s = 0; s < NS; s++) begin
                s_ack[s] = ($urandom_range(0, 4) == 0);
                s_err[s] = ($urandom_range(0, 11) == 0);
            end
            s_dat_r = {$urandom, $urandom, $urandom};
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_arb_xbar.md
Name: wb_arb_xbar

Overview:
- Parametrised Wishbone shared-bus interconnect, successor to the fixed 8x16 connection matrix in the SoC top level.
- Connects NM masters (CPU imem/dmem ports, future DMA) to NS slaves (BRAM bridges, peripheral decoder) through one shared bus.
- Adds round-robin arbitration, slave decode on top address bits, and a bus-timeout/unmapped-address error path that the current interconnect lacks.

Parameters:
- NM, 2, number of masters (1..8)
- NS, 3, number of slaves (1..16)
- AW, 32, address width
- DW, 32, data width (multiple of 8); SW = DW/8 is the select width
- SEL_BITS, 4, number of top address bits used as the slave index
- TIMEOUT, 255, cycles of unanswered stb before err is forced (8-bit counter; 0 disables)

Ports:
- clk_i  in  1  bus clock
- rst_i  in  1  synchronous, active-high reset
- m_cyc_i  in  NM  per-master cycle
- m_stb_i  in  NM  per-master strobe
- m_we_i  in  NM  per-master write enable
- m_sel_i  in  NM*SW  byte selects; master k occupies [k*SW +: SW]
- m_adr_i  in  NM*AW  addresses
- m_dat_i  in  NM*DW  write data
- m_dat_o  out  NM*DW  read data; valid only with that master's ack
- m_ack_o  out  NM  acknowledge
- m_err_o  out  NM  error (decode miss or timeout)
- s_cyc_o  out  NS  per-slave cycle
- s_stb_o  out  NS  per-slave strobe
- s_we_o  out  1  shared write enable
- s_sel_o  out  SW  shared byte selects
- s_adr_o  out  AW  shared address
- s_dat_o  out  DW  shared write data
- s_dat_i  in  NS*DW  slave read data
- s_ack_i  in  NS  slave acknowledge
- s_err_i  in  NS  slave error
- gnt_o  out  NM  one-hot current owner (all zero = bus idle), debug/observability

Behaviour:
- Reset: at the first clk_i edge with rst_i=1, gnt_o=0, last_owner=NM-1, timeout counter=0, err pulse register=0. All strobe/ack/err outputs are then 0, because they are gated by gnt_o. s_adr_o, s_dat_o, s_sel_o and s_we_o are 0 when gnt_o=0.
- Reset asserted mid-transfer aborts the transfer with no ack/err. The master must re-issue it.
- Arbiter FSM has two states: IDLE (gnt_o=0) and OWNED.
- IDLE: if any m_cyc_i is set, grant the first requester scanning from (last_owner+1) mod NM with wrap. The grant is registered, so the owner appears one cycle after its cyc is sampled. Go to OWNED.
- OWNED: hold the grant while the owner's m_cyc_i=1; no preemption.
- When the owner drops cyc: if another master's cyc is set, re-arbitrate in the same cycle (new grant on the next edge) and set last_owner=old owner; otherwise go to IDLE.
- Decode: idx = owner m_adr_i[AW-1 -: SEL_BITS]. The address is hit when idx < NS.
- Hit: s_cyc_o[idx] = owner cyc; s_stb_o[idx] = owner stb; all other slave bits are 0.
- Shared outputs s_we_o, s_sel_o, s_adr_o and s_dat_o are muxed from the owner unmodified.
- Response path is combinational:
  - m_ack_o[owner] = s_ack_i[idx]
  - m_dat_o[owner] = s_dat_i[idx]
  - m_err_o[owner] = s_err_i[idx] | err_pulse
  - Non-owner m_ack_o and m_err_o are 0. Non-owner m_dat_o is 0.
- Miss (idx >= NS): no s_stb_o is asserted. err_pulse is set on the edge after stb is sampled with a miss, so it appears 1 cycle later and lasts exactly 1 cycle. The next cycle err_pulse is forced 0 even if stb is still high. A held miss therefore yields err every second cycle.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle owner stb=1 with a hit and no s_ack_i[idx]/s_err_i[idx].
  - It clears on ack, err, stb=0, or grant change.
  - When it reaches TIMEOUT: raise err_pulse for 1 cycle, clear the counter, deassert s_stb_o[idx] that same cycle.
- Simultaneous events:
  - A slave ack in the same cycle as timeout expiry wins: ack only, no err.
  - Owner cyc dropping in the same cycle as a slave ack: the ack is still routed that cycle.
- Width rule: the counter saturates logic at 8 bits, so TIMEOUT > 255 is illegal. An elaboration check enforces NM>=1, NS>=1, NS<=2**SEL_BITS.

Decomposition:
- Package wb_pkg holds:
  - the arbiter state enum {ARB_IDLE, ARB_OWNED}
  - the constant WB_TO_W=8
  - the function rr_pick(req, last) returning a one-hot grant
- One sub-module, wb_rr_arb:
  - inputs: clk_i, rst_i, req[NM], release
  - outputs: gnt[NM], gnt_idx
  - contains the FSM and last_owner
- The top holds decode, muxing, the timeout counter and err_pulse.

Test Plan:
- Single master read: NM=2, NS=3. m0 cyc/stb, adr=0x1000_0040. The slave acks 1 cycle after stb with 0xDEADBEEF. Required: gnt_o=01 one cycle after cyc; s_stb_o=010; m_ack_o[0]=1 with m_dat_o[0]=0xDEADBEEF.
- Round-robin: m0 and m1 assert cyc together, each doing 3 back-to-back single transfers. Required grant order m0,m1,m0,m1,m0,m1; no cycle with 2 grant bits set.
- Decode miss: m1 writes adr=0x5000_0000 and holds stb 4 cycles. Required: s_stb_o=000 throughout; m_err_o[1] pattern 0,1,0,1.
- Timeout: TIMEOUT=4, slave 0 never acks, m0 reads 0x0000_0000. Required: m_err_o[0]=1 on the 4th stalled cycle; s_stb_o[0]=0 that cycle; counter restarts.
- Ack/timeout tie: TIMEOUT=4, slave acks exactly on the 4th stalled cycle. Required: m_ack_o=1, m_err_o=0.
- Reset mid-burst: assert rst_i for 1 cycle during an m0 transfer. Required: gnt_o=00 and all s_stb_o/m_ack_o/m_err_o=0 the next cycle; the first re-arbitration after reset grants m0 when both request.
